// File: rtl/irq_sequencer.sv
// irq_sequencer: queues button interrupt edges in arrival order and sequences core entry,
// register stacking, handler service, unstacking and return.
module irq_sequencer #(
    parameter int          FIFO_DEPTH    = 4,
    parameter int          STACK_REGS    = 31,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [63:0] VECTOR_BASE   = 64'h0000_0000_0000_0100,
    parameter logic [63:0] VECTOR_STRIDE = 64'h40
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [3:0]  external_button_in,
    input  logic [3:0]  irq_enable_in,
    input  logic        core_ack_in,
    input  logic        mret_in,
    output logic        interrupt_signal_out,
    output logic        stacking_signal_out,
    output logic        unstacking_signal_out,
    output logic        return_interrupt_signal_out,
    output logic [4:0]  stack_index_out,
    output logic [1:0]  irq_id_out,
    output logic [63:0] handler_pc_out,
    output logic        empty_fifo_signal_out,
    output logic        fifo_full_out,
    output logic [7:0]  dropped_count_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] LAST = 5'(STACK_REGS);

    typedef enum logic [2:0] {IDLE, REQ, STACK, SERVICE, UNSTACK, RETURN} state_e;

    state_e      state_q;
    logic [3:0]  sync_q [SYNC_STAGES];
    logic [3:0]  prev_q;
    logic [3:0]  pend_q, pend_d;
    logic [1:0]  fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic [7:0]  drop_q;
    logic        int_q, stk_q, unstk_q, ret_q;
    logic [4:0]  idx_q;
    logic [1:0]  id_q;
    logic [63:0] pc_q;
    logic [3:0]  edge_v, lost;
    logic [2:0]  lost_n;
    logic [8:0]  drop_sum;
    logic [1:0]  enq_id;
    logic        enq_v, full, pop;

    assign edge_v   = sync_q[SYNC_STAGES-1] & ~prev_q & irq_enable_in;
    // An edge landing on an already pending line is lost, even if that bit is leaving this cycle
    assign lost     = edge_v & pend_q;
    assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign enq_v    = |pend_q & ~full;
    assign pop      = state_q == IDLE && cnt_q != '0;
    assign pend_d   = (pend_q & ~(enq_v ? 4'b1 << enq_id : 4'b0)) | (edge_v & ~pend_q);
    assign drop_sum = {1'b0, drop_q} + {6'b0, lost_n};

    always_comb begin
        enq_id = '0;
        lost_n = '0;
        for (int i = 3; i >= 0; i--) enq_id = pend_q[i] ? 2'(i) : enq_id;
        for (int i = 0; i < 4; i++) lost_n = lost_n + 3'(lost[i]);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
            pend_q <= '0;
            drop_q <= '0;
        end else begin
            sync_q[0] <= external_button_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
            pend_q <= pend_d;
            drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (enq_v) fifo_q[wr_q] <= enq_id;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(enq_v);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_q + (AW+1)'(enq_v) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            stk_q   <= 1'b0;
            unstk_q <= 1'b0;
            ret_q   <= 1'b0;
            idx_q   <= '0;
            id_q    <= '0;
            pc_q    <= '0;
        end else begin
            ret_q <= 1'b0;
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= REQ;
                    id_q    <= fifo_q[rd_q];
                    int_q   <= 1'b1;
                end
                REQ: if (core_ack_in) begin
                    state_q <= STACK;
                    int_q   <= 1'b0;
                    stk_q   <= 1'b1;
                    idx_q   <= 5'd1;
                end
                STACK: if (idx_q == LAST) begin
                    state_q <= SERVICE;
                    stk_q   <= 1'b0;
                    idx_q   <= '0;
                    pc_q    <= VECTOR_BASE + 64'(id_q) * VECTOR_STRIDE;
                end else idx_q <= idx_q + 5'd1;
                SERVICE: if (mret_in) begin
                    state_q <= UNSTACK;
                    pc_q    <= '0;
                    unstk_q <= 1'b1;
                    idx_q   <= LAST;
                end
                UNSTACK: if (idx_q == 5'd1) begin
                    state_q <= RETURN;
                    unstk_q <= 1'b0;
                    idx_q   <= '0;
                    ret_q   <= 1'b1;
                end else idx_q <= idx_q - 5'd1;
                default: begin
                    state_q <= IDLE;
                    id_q    <= '0;
                end
            endcase
        end
    end

    assign interrupt_signal_out        = int_q;
    assign stacking_signal_out         = stk_q;
    assign unstacking_signal_out       = unstk_q;
    assign return_interrupt_signal_out = ret_q;
    assign stack_index_out             = idx_q;
    assign irq_id_out                  = id_q;
    assign handler_pc_out              = pc_q;
    assign empty_fifo_signal_out       = cnt_q == '0;
    assign fifo_full_out               = full;
    assign dropped_count_out           = drop_q;
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference model of the interrupt sequencer.
module tb_irq_sequencer;
    localparam int S = 2, DEPTH = 4, SR = 31;

    logic        clk = 1'b0, rst = 1'b1, ack = 1'b0, mret = 1'b0;
    logic [3:0]  btn = 4'b0, en = 4'hF;
    logic        interrupt_signal_out, stacking_signal_out, unstacking_signal_out;
    logic        return_interrupt_signal_out, empty_fifo_signal_out, fifo_full_out;
    logic [4:0]  stack_index_out;
    logic [1:0]  irq_id_out;
    logic [63:0] handler_pc_out;
    logic [7:0]  dropped_count_out;

    irq_sequencer dut (
        .Clk(clk), .Rst(rst), .external_button_in(btn), .irq_enable_in(en),
        .core_ack_in(ack), .mret_in(mret),
        .interrupt_signal_out(interrupt_signal_out), .stacking_signal_out(stacking_signal_out),
        .unstacking_signal_out(unstacking_signal_out),
        .return_interrupt_signal_out(return_interrupt_signal_out),
        .stack_index_out(stack_index_out), .irq_id_out(irq_id_out),
        .handler_pc_out(handler_pc_out), .empty_fifo_signal_out(empty_fifo_signal_out),
        .fifo_full_out(fifo_full_out), .dropped_count_out(dropped_count_out)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    typedef enum int {P_IDLE, P_REQ, P_STK, P_SVC, P_UNS, P_RET} phase_e;
    phase_e     ph;
    int         left, drops;
    logic [1:0] m_id;
    logic [3:0] pend;
    logic [1:0] q[$];
    logic [3:0] hist[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE; left = 0; drops = 0; m_id = 0; pend = 0;
        q.delete(); hist.delete();
        repeat (S + 1) hist.push_back(4'b0);
    endtask

    task automatic model_edge();
        logic [3:0] e;
        int enq;
        bit pop;
        if (rst) begin
            model_reset();
            return;
        end
        e   = hist[S-1] & ~hist[S] & en;
        enq = -1;
        if (q.size() < DEPTH) for (int i = 3; i >= 0; i--) if (pend[i]) enq = i;
        pop = ph == P_IDLE && q.size() > 0;
        for (int i = 0; i < 4; i++) if (e[i] && pend[i] && drops < 255) drops++;
        e = e & ~pend;
        if (enq >= 0) pend[enq] = 1'b0;
        pend = pend | e;
        if (pop) m_id = q.pop_front();
        if (enq >= 0) q.push_back(2'(enq));
        case (ph)
            P_IDLE: if (pop) ph = P_REQ;
            P_REQ:  if (ack) begin ph = P_STK; left = SR; end
            P_STK:  begin left--; if (left == 0) ph = P_SVC; end
            P_SVC:  if (mret) begin ph = P_UNS; left = SR; end
            P_UNS:  begin left--; if (left == 0) ph = P_RET; end
            default: ph = P_IDLE;
        endcase
        hist.push_front(btn);
        void'(hist.pop_back());
    endtask

    task automatic compare_all();
        check("interrupt", interrupt_signal_out, ph == P_REQ);
        check("stacking", stacking_signal_out, ph == P_STK);
        check("unstacking", unstacking_signal_out, ph == P_UNS);
        check("return", return_interrupt_signal_out, ph == P_RET);
        check("stack_index", stack_index_out, ph == P_STK ? SR - left + 1 : ph == P_UNS ? left : 0);
        check("handler_pc", handler_pc_out, ph == P_SVC ? 64'h100 + 64'(m_id) * 64'h40 : 64'h0);
        check("empty", empty_fifo_signal_out, q.size() == 0);
        check("full", fifo_full_out, q.size() == DEPTH);
        check("dropped", dropped_count_out, drops);
        if (ph != P_IDLE) check("irq_id", irq_id_out, m_id);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic logic sigv(input int w);
        case (w)
            0: return interrupt_signal_out;
            1: return stacking_signal_out;
            2: return unstacking_signal_out;
            default: return return_interrupt_signal_out;
        endcase
    endfunction

    task automatic wait_sig(input int w, input logic v, input int budget, input string tag);
        int n = 0;
        while (sigv(w) !== v && n < budget) begin step(); n++; end
        check(tag, sigv(w), v);
    endtask

    task automatic serve_one(input int ack_dly, output logic [1:0] id, output logic [63:0] pc);
        wait_sig(0, 1'b1, 40, "wait_req");
        id = irq_id_out;
        repeat (ack_dly) step();
        ack = 1'b1; step(); ack = 1'b0;
        wait_sig(1, 1'b0, 40, "wait_service");
        pc = handler_pc_out;
        step();
        mret = 1'b1; step(); mret = 1'b0;
        wait_sig(3, 1'b1, 40, "wait_return");
        step();
    endtask

    initial begin
        int n;
        logic [1:0] id;
        logic [63:0] pc;
        model_reset();
        step(); step();
        rst = 1'b0;
        check("rst_empty", empty_fifo_signal_out, 1);
        check("rst_int", interrupt_signal_out, 0);
        check("rst_dropped", dropped_count_out, 0);

        mret = 1'b1; step(); mret = 1'b0;
        btn = 4'b0001; step(); btn = 4'b0;
        n = 0;
        while (!interrupt_signal_out && n < 20) begin step(); n++; end
        check("req_latency", n, 4);
        repeat (2) step();
        ack = 1'b1; step(); ack = 1'b0;
        n = 0;
        while (stacking_signal_out && n < 40) begin mret = n == 5; step(); n++; end
        mret = 1'b0;
        check("stack_len", n, 31);
        check("pc_id0", handler_pc_out, 64'h100);
        repeat (2) step();
        mret = 1'b1; step(); mret = 1'b0;
        n = 0;
        while (unstacking_signal_out && n < 40) begin step(); n++; end
        check("unstack_len", n, 31);
        check("ret_pulse", return_interrupt_signal_out, 1);
        step();
        check("ret_one_cycle", return_interrupt_signal_out, 0);
        check("empty_after", empty_fifo_signal_out, 1);

        btn = 4'b1010; step(); btn = 4'b0;
        serve_one(0, id, pc);
        check("simul_id_first", id, 1);
        check("simul_pc_first", pc, 64'h140);
        serve_one(2, id, pc);
        check("simul_id_second", id, 3);
        check("simul_pc_second", pc, 64'h1C0);
        check("simul_dropped", dropped_count_out, 0);

        en = 4'b1110;
        btn = 4'b0001; step(); btn = 4'b0;
        repeat (10) step();
        check("mask_empty", empty_fifo_signal_out, 1);
        check("mask_int", interrupt_signal_out, 0);
        check("mask_dropped", dropped_count_out, 0);
        en = 4'hF;

        btn = 4'b0001; step(); btn = 4'b0;
        wait_sig(0, 1'b1, 20, "ovf_req");
        repeat (6) begin btn = 4'b0100; step(); btn = 4'b0; step(); step(); end
        check("ovf_full", fifo_full_out, 1);
        check("ovf_dropped", dropped_count_out, 1);
        for (int k = 0; k < 6; k++) begin
            serve_one(1, id, pc);
            check("ovf_id", id, k == 0 ? 0 : 2);
        end
        repeat (4) step();
        check("ovf_drained", empty_fifo_signal_out, 1);

        btn = 4'b0010; step(); btn = 4'b0;
        wait_sig(0, 1'b1, 20, "mid_req");
        ack = 1'b1; step(); ack = 1'b0;
        n = 0;
        while (stack_index_out != 5'd10 && n < 40) begin step(); n++; end
        check("mid_idx10", stack_index_out, 10);
        rst = 1'b1; step(); rst = 1'b0;
        check("mid_rst_stk", stacking_signal_out, 0);
        check("mid_rst_idx", stack_index_out, 0);
        check("mid_rst_ret", return_interrupt_signal_out, 0);
        check("mid_rst_id", irq_id_out, 0);
        check("mid_rst_empty", empty_fifo_signal_out, 1);
        check("mid_rst_dropped", dropped_count_out, 0);
        step();
        check("mid_no_ret", return_interrupt_signal_out, 0);
        btn = 4'b0100; step(); btn = 4'b0;
        serve_one(0, id, pc);
        check("fresh_id", id, 2);
        check("fresh_pc", pc, 64'h180);

        repeat (4000) begin
            btn  = btn ^ (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0);
            en   = ($urandom_range(0, 49) == 0) ? 4'($urandom) : en;
            ack  = $urandom_range(0, 3) == 0;
            mret = $urandom_range(0, 9) == 0;
            rst  = $urandom_range(0, 1999) == 0;
            step();
        end
        rst = 1'b0; ack = 1'b0; mret = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
